// File: rtl/twiddle_pkg.sv
// Shared types and elaboration-time helpers for the radix-4 twiddle generator.
package twiddle_pkg;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  function automatic int stage_k(input int c, input int first_k = 2);
    return first_k + c;
  endfunction

  // round(cos(2*pi*x/N) * (2^(tw-1)-1)) via a Q30 Taylor series, so no real math is needed.
  function automatic int quarter_cos(input int x, input int log2_n, input int tw);
    longint theta;
    longint theta2;
    longint term;
    longint sum;
    longint scale;
    theta  = (64'sd3373259426 * longint'(x)) >>> (log2_n - 1);
    theta2 = (theta * theta) >>> 30;
    term   = 64'sd1 <<< 30;
    sum    = term;
    for (int n = 1; n <= 12; n++) begin
      term = -((term * theta2) >>> 30) / longint'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    scale = (64'sd1 <<< (tw - 1)) - 64'sd1;
    return int'((sum * scale + (64'sd1 <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/twiddle_quarter_rom.sv
// Quarter-wave cosine table with two registered read ports (cos at r, sin via N/4-r).
module twiddle_quarter_rom
  import twiddle_pkg::*;
#(
  parameter int LOG2_N = 12,
  parameter int TW     = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LOG2_N-2:0]    addr_a,
  input  logic [LOG2_N-2:0]    addr_b,
  output logic signed [TW-1:0] data_a,
  output logic signed [TW-1:0] data_b
);

  localparam int DEPTH = (1 << (LOG2_N - 2)) + 1;

  logic signed [TW-1:0] rom_s [0:DEPTH-1];
  logic signed [TW-1:0] data_a_q;
  logic signed [TW-1:0] data_b_q;

  for (genvar x = 0; x < DEPTH; x++) begin : g_tab
    localparam int VAL = quarter_cos(x, LOG2_N, TW);
    assign rom_s[x] = TW'(VAL);
  end

  // Synchronous read of both ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      data_a_q <= rom_s[addr_a];
      data_b_q <= rom_s[addr_b];
    end
  end

  assign data_a = data_a_q;
  assign data_b = data_b_q;

endmodule

// File: rtl/twiddle_gen_param.sv
// Multi-stage radix-4 twiddle generator: per-channel counters, shared quarter-wave
// table content, quadrant fold and optional conjugation; two-cycle latency.
module twiddle_gen_param
  import twiddle_pkg::*;
#(
  parameter int LOG2_N  = 12,
  parameter int NUM_CH  = 5,
  parameter int FIRST_K = 2,
  parameter int TW      = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     start,
  input  logic                     inverse,
  output logic [NUM_CH*2*TW-1:0]   omega_o,
  output logic                     valid_o
);

  localparam int AW = LOG2_N - 1;
  localparam logic [AW-1:0] QUARTER = AW'(1) << (LOG2_N - 2);

  logic                   inv_d;
  logic                   inv_q;
  logic                   inv_s1_q;
  logic                   valid_s1_q;
  logic                   valid_q;
  logic [NUM_CH*2*TW-1:0] omega_d;
  logic [NUM_CH*2*TW-1:0] omega_q;

  // A start applies the new mode to the very set emitted in the same cycle.
  always_comb begin
    if (start) begin
      inv_d = inverse;
    end else begin
      inv_d = inv_q;
    end
  end

  // Shared control: mode register and the sidecar pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q      <= 1'b0;
      inv_s1_q   <= 1'b0;
      valid_s1_q <= 1'b0;
      valid_q    <= 1'b0;
      omega_q    <= '0;
    end else begin
      inv_q      <= inv_d;
      inv_s1_q   <= inv_d;
      valid_s1_q <= enable;
      valid_q    <= valid_s1_q;
      omega_q    <= omega_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int K  = stage_k(c, FIRST_K);
    localparam int MW = 2 * K;

    logic [MW-1:0]        m_d;
    logic [MW-1:0]        m_q;
    logic [MW-1:0]        m_use_s;
    logic [LOG2_N-1:0]    idx_s;
    logic [AW-1:0]        addr_a_s;
    logic [AW-1:0]        addr_b_s;
    quad_e                quad_d;
    quad_e                quad_q;
    logic signed [TW-1:0] cos_s;
    logic signed [TW-1:0] sin_s;
    logic signed [TW-1:0] re_s;
    logic signed [TW-1:0] im_s;
    logic signed [TW-1:0] im_out_s;

    // Scaling by 4^(LOG2_N/2-K) maps every stage onto the same N-point circle.
    always_comb begin
      if (start) begin
        m_use_s = '0;
        m_d     = enable ? MW'(1) : '0;
      end else if (enable) begin
        m_use_s = m_q;
        m_d     = m_q + MW'(1);
      end else begin
        m_use_s = m_q;
        m_d     = m_q;
      end
      idx_s    = LOG2_N'(m_use_s) << (LOG2_N - MW);
      quad_d   = quad_e'(idx_s[LOG2_N-1 -: 2]);
      addr_a_s = {1'b0, idx_s[LOG2_N-3:0]};
      addr_b_s = QUARTER - addr_a_s;
    end

    // Per-channel phase counter and quadrant sidecar.
    always_ff @(posedge clk) begin
      if (rst) begin
        m_q    <= '0;
        quad_q <= QUAD_0;
      end else begin
        m_q    <= m_d;
        quad_q <= quad_d;
      end
    end

    twiddle_quarter_rom #(
      .LOG2_N (LOG2_N),
      .TW     (TW)
    ) u_rom (
      .clk    (clk),
      .rst    (rst),
      .addr_a (addr_a_s),
      .addr_b (addr_b_s),
      .data_a (cos_s),
      .data_b (sin_s)
    );

    // Quadrant fold; the table never holds -2^(TW-1), so negation is exact.
    always_comb begin
      case (quad_q)
        QUAD_0: begin re_s = cos_s;  im_s = -sin_s; end
        QUAD_1: begin re_s = -sin_s; im_s = -cos_s; end
        QUAD_2: begin re_s = -cos_s; im_s = sin_s;  end
        QUAD_3: begin re_s = sin_s;  im_s = cos_s;  end
        default: begin re_s = '0;    im_s = '0;     end
      endcase
      if (inv_s1_q) begin
        im_out_s = -im_s;
      end else begin
        im_out_s = im_s;
      end
    end

    assign omega_d[c*2*TW +: 2*TW] = valid_s1_q ? {re_s, im_out_s} : '0;
  end

  assign omega_o = omega_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_twiddle_gen_param.sv
// Directed bench for twiddle_gen_param: real-valued exp(-j*2*pi*m/4^k) model plus literal pins.
module tb_twiddle_gen_param;

  localparam int LOG2_N  = 12;
  localparam int NUM_CH  = 5;
  localparam int FIRST_K = 2;
  localparam int TW      = 9;
  localparam int W       = NUM_CH * 2 * TW;
  localparam int PER     = 1 << (2 * (FIRST_K + NUM_CH - 1));
  localparam real PI     = 3.14159265358979323846;
  localparam real AMP    = 255.0;

  logic         clk;
  logic         rst;
  logic         enable;
  logic         start;
  logic         inverse;
  logic [W-1:0] omega_o;
  logic         valid_o;

  int n_cmp;
  int n_bad;
  logic armed;
  logic done;

  // Model state: running index since the last start, latched mode, 2-deep delay line.
  int   cnt_m;
  logic inv_m;
  logic e1_v, e1_z, e1_inv, e2_v, e2_z, e2_inv;
  int   e1_cnt, e2_cnt;

  twiddle_gen_param #(
    .LOG2_N  (LOG2_N),
    .NUM_CH  (NUM_CH),
    .FIRST_K (FIRST_K),
    .TW      (TW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .start   (start),
    .inverse (inverse),
    .omega_o (omega_o),
    .valid_o (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else return -$rtoi(-v + 0.5);
  endfunction

  function automatic logic [2*TW-1:0] model_ch(input int c, input int cnt, input logic inv);
    int  per;
    int  m;
    int  re;
    int  im;
    real ang;
    per = 1 << (2 * (FIRST_K + c));
    m   = cnt % per;
    ang = 2.0 * PI * real'(m) / real'(per);
    re  = rnd($cos(ang) * AMP);
    im  = rnd(-$sin(ang) * AMP);
    if (inv) im = -im;
    return {re[TW-1:0], im[TW-1:0]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      cnt_m  <= 0;
      inv_m  <= 1'b0;
      e1_v   <= 1'b0;
      e1_z   <= 1'b1;
      e1_inv <= 1'b0;
      e1_cnt <= 0;
      e2_v   <= 1'b0;
      e2_z   <= 1'b1;
      e2_inv <= 1'b0;
      e2_cnt <= 0;
      armed  <= 1'b1;
    end else begin
      e1_v   <= enable;
      e1_z   <= e1_z && !enable;
      e1_cnt <= start ? 0 : cnt_m;
      e1_inv <= start ? inverse : inv_m;
      e2_v   <= e1_v;
      e2_z   <= e1_z;
      e2_cnt <= e1_cnt;
      e2_inv <= e1_inv;
      if (start) inv_m <= inverse;
      if (start) cnt_m <= enable ? 1 : 0;
      else if (enable) cnt_m <= (cnt_m + 1) % PER;
    end
  end

  always @(negedge clk) begin
    if (armed && !done) begin
      chk("valid", W'(valid_o), W'(e2_v));
      if (!e2_v && e2_z) chk("idle_zero", omega_o, '0);
      if (e2_v) begin
        for (int c = 0; c < NUM_CH; c++) begin
          logic [2*TW-1:0] act;
          int m;
          m   = e2_cnt % (1 << (2 * (FIRST_K + c)));
          act = omega_o[c*2*TW +: 2*TW];
          chk($sformatf("ch%0d_m%0d_inv%0d", c, m, e2_inv), W'(act), W'(model_ch(c, e2_cnt, e2_inv)));
          if (m == 0) chk($sformatf("pin_ch%0d_m0", c), W'(act), W'(18'h1FE00));
          if (c == 0 && m == 4) chk("pin_ch0_m4", W'(act), W'(e2_inv ? 18'h000FF : 18'h00101));
          if (c == 0 && m == 8) chk("pin_ch0_m8", W'(act), W'(18'h20200));
          if (c == 0 && m == 12) chk("pin_ch0_m12", W'(act), W'(e2_inv ? 18'h00101 : 18'h000FF));
          if (c == 4 && m == 1024) chk("pin_ch4_m1024", W'(act), W'(e2_inv ? 18'h000FF : 18'h00101));
        end
      end
    end
  end

  task automatic step(input logic en, input logic st, input logic inv);
    enable  = en;
    start   = st;
    inverse = inv;
    @(negedge clk);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    armed   = 1'b0;
    done    = 1'b0;
    rst     = 1'b1;
    enable  = 1'b0;
    start   = 1'b0;
    inverse = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", W'(valid_o), W'(1'b0));
      chk("rst_omega", omega_o, '0);
    end
    rst = 1'b0;
    repeat (3) begin
      step(1'b0, 1'b0, 1'b0);
      chk("idle_valid", W'(valid_o), W'(1'b0));
      chk("idle_omega", omega_o, '0);
    end
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Channel 0 forward sweep with wrap.
    step(1'b0, 1'b1, 1'b0);
    repeat (17) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Inverse mode, long enough to reach ch4 m=1024.
    step(1'b1, 1'b1, 1'b1);
    repeat (1100) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Enable gaps.
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Restart at m=2000.
    step(1'b1, 1'b1, 1'b0);
    repeat (1999) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Reset at m=3000.
    step(1'b1, 1'b1, 1'b0);
    repeat (2999) step(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    chk("midrst_valid", W'(valid_o), W'(1'b0));
    chk("midrst_omega", omega_o, '0);
    rst = 1'b0;
    repeat (5) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Full sweep of ch4 plus wrap.
    step(1'b1, 1'b1, 1'b0);
    repeat (4097) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
